// File: rtl/sap_cpu_core.sv
// Parametrised accumulator CPU core with load/store, add/subtract, carry/zero flags and conditional jumps.
// Optional build macro SAP_CPU_ILLEGAL_TRAP_EN: illegal opcodes halt the core with an all-ones trap signature.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    localparam int AW = DATA_W - 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_out,
    output logic              o_out_valid,
    output logic              o_halted,
    output logic [AW-1:0]     o_pc
);

    localparam logic [2:0] FETCH_A = 3'd0;
    localparam logic [2:0] FETCH_W = 3'd1;
    localparam logic [2:0] DECODE  = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] MEM_W   = 3'd4;
    localparam logic [2:0] WB      = 3'd5;
    localparam logic [2:0] HALT    = 3'd6;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [2:0]        state_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] ir_r;
    logic              c_r;
    logic              z_r;

    logic [3:0]        opcode_s;
    logic [AW-1:0]     imm_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W:0]   add_s;
    logic [DATA_W:0]   sub_s;

    // Instruction field decode and ALU; the B operand is the RAM's registered read word during WB.
    always_comb begin
        opcode_s  = ir_r[DATA_W-1 -: 4];
        imm_s     = ir_r[AW-1:0];
        imm_ext_s = {4'b0000, imm_s};
        add_s     = {1'b0, a_r} + {1'b0, i_mem_rdata};
        sub_s     = {1'b0, a_r} - {1'b0, i_mem_rdata};
    end

    // Fetch/decode/execute sequencer; strobes default low and pulse for exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= FETCH_A;
            o_pc        <= {AW{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            ir_r        <= {DATA_W{1'b0}};
            c_r         <= 1'b0;
            z_r         <= 1'b0;
            o_out       <= {DATA_W{1'b0}};
            o_out_valid <= 1'b0;
            o_halted    <= 1'b0;
            o_mem_addr  <= {AW{1'b0}};
            o_mem_re    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            o_mem_re    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_out_valid <= 1'b0;
            case (state_r)
                FETCH_A: begin
                    o_mem_addr <= o_pc;
                    o_mem_re   <= 1'b1;
                    state_r    <= FETCH_W;
                end
                FETCH_W: state_r <= DECODE;
                DECODE: begin
                    ir_r    <= i_mem_rdata;
                    o_pc    <= o_pc + AW'(1);
                    state_r <= EXEC;
                end
                EXEC: begin
                    state_r <= FETCH_A;
                    case (opcode_s)
                        OP_NOP: state_r <= FETCH_A;
                        OP_LDI: a_r <= imm_ext_s;
                        OP_JMP: o_pc <= imm_s;
                        OP_JC: begin
                            if (c_r) o_pc <= imm_s;
                        end
                        OP_JZ: begin
                            if (z_r) o_pc <= imm_s;
                        end
                        OP_OUT: begin
                            o_out       <= a_r;
                            o_out_valid <= 1'b1;
                        end
                        OP_STA: begin
                            o_mem_addr  <= imm_s;
                            o_mem_wdata <= a_r;
                            o_mem_we    <= 1'b1;
                        end
                        OP_LDA, OP_ADD, OP_SUB: begin
                            o_mem_addr <= imm_s;
                            o_mem_re   <= 1'b1;
                            state_r    <= MEM_W;
                        end
                        OP_HLT: begin
                            o_halted <= 1'b1;
                            state_r  <= HALT;
                        end
`ifdef SAP_CPU_ILLEGAL_TRAP_EN
                        default: begin
                            o_halted    <= 1'b1;
                            o_out       <= {DATA_W{1'b1}};
                            o_out_valid <= 1'b1;
                            state_r     <= HALT;
                        end
`else
                        default: state_r <= FETCH_A;
`endif
                    endcase
                end
                MEM_W: state_r <= WB;
                WB: begin
                    state_r <= FETCH_A;
                    case (opcode_s)
                        OP_LDA: a_r <= i_mem_rdata;
                        OP_ADD: begin
                            a_r <= add_s[DATA_W-1:0];
                            c_r <= add_s[DATA_W];
                            z_r <= (add_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        end
                        OP_SUB: begin
                            a_r <= sub_s[DATA_W-1:0];
                            c_r <= ~sub_s[DATA_W];
                            z_r <= (sub_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        end
                        default: state_r <= FETCH_A;
                    endcase
                end
                HALT: state_r <= HALT;
                default: state_r <= FETCH_A;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Bench for sap_cpu_core: directed program table, hand sequences, and random programs vs an ISA-level model.
module tb_sap_cpu_core;

    logic       clk;
    logic       rst8;
    logic [3:0] addr8, pc8;
    logic       re8, we8, ov8, halted8;
    logic [7:0] wdata8, rdata8, out8;
    logic [7:0] ram8 [16];

    logic        rst12;
    logic [7:0]  addr12, pc12;
    logic        re12, we12, ov12, halted12;
    logic [11:0] wdata12, rdata12, out12;
    logic [11:0] ram12 [256];

    int checks = 0;
    int errors = 0;

    typedef struct { int e; int a; int v; } ev_t;
    ev_t dut_out_q[$], dut_wr_q[$], exp_out_q[$], exp_wr_q[$];
    int  dut_halt, exp_halt, after_halt, overlap;

    typedef struct {
        string        name;
        logic [127:0] img;
        int           halt_e;
        int           nout;
        logic [7:0]   out;
        int           nwr;
        logic [3:0]   waddr;
        logic [7:0]   wdata;
    } vec_t;
    vec_t vecs[12];

    sap_cpu_core #(.DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst8), .o_mem_addr(addr8), .o_mem_re(re8), .o_mem_we(we8),
        .o_mem_wdata(wdata8), .i_mem_rdata(rdata8), .o_out(out8), .o_out_valid(ov8),
        .o_halted(halted8), .o_pc(pc8)
    );

    sap_cpu_core #(.DATA_W(12)) dut12 (
        .i_clk(clk), .i_rst(rst12), .o_mem_addr(addr12), .o_mem_re(re12), .o_mem_we(we12),
        .o_mem_wdata(wdata12), .i_mem_rdata(rdata12), .o_out(out12), .o_out_valid(ov12),
        .o_halted(halted12), .o_pc(pc12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: read word registered on the edge that sees the read strobe.
    always @(posedge clk) begin
        if (re8) rdata8 <= ram8[addr8];
        if (we8) ram8[addr8] = wdata8;
        if (re12) rdata12 <= ram12[addr12];
        if (we12) ram12[addr12] = wdata12;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load8(input logic [127:0] img);
        for (int i = 0; i < 16; i++) ram8[i] = img[127-8*i -: 8];
    endtask

    task automatic reset8(input logic [127:0] img);
        @(negedge clk);
        rst8 = 1'b0;
        load8(img);
        #1;
        chk("reset_state", {4'h0, pc8, addr8, re8, we8, wdata8, out8, ov8, halted8}, 32'd0);
        @(negedge clk);
        rst8 = 1'b1;
    endtask

    // Runs budget edges after reset release, recording events by edge number.
    task automatic run8(input int budget);
        dut_out_q.delete();
        dut_wr_q.delete();
        dut_halt = -1;
        after_halt = 0;
        overlap = 0;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            #1;
            if (ov8) dut_out_q.push_back('{e, 0, int'(out8)});
            if (we8) dut_wr_q.push_back('{e, int'(addr8), int'(wdata8)});
            if (re8 && we8) overlap++;
            if (halted8 && dut_halt < 0) dut_halt = e;
            else if (dut_halt >= 0 && (re8 || we8 || ov8)) after_halt++;
        end
    endtask

    // Instruction-level reference: each instruction costs 4 or 6 edges, events land at start+4.
    task automatic model8(input logic [127:0] img, input int budget);
        int m[16];
        int t, pc, a, op, imm, v;
        bit c, z, halted;
        t = 0; pc = 0; a = 0; c = 0; z = 0; halted = 0;
        exp_out_q.delete();
        exp_wr_q.delete();
        exp_halt = -1;
        for (int i = 0; i < 16; i++) m[i] = int'(img[127-8*i -: 8]);
        while (!halted && t + 4 <= budget) begin
            op = m[pc] / 16;
            imm = m[pc] % 16;
            pc = (pc + 1) % 16;
            case (op)
                1: begin a = m[imm]; t += 2; end
                2: begin v = a + m[imm]; c = (v > 255); a = v % 256; z = (a == 0); t += 2; end
                3: begin c = (a >= m[imm]); a = (a - m[imm] + 256) % 256; z = (a == 0); t += 2; end
                4: begin exp_wr_q.push_back('{t + 4, imm, a}); m[imm] = a; end
                5: a = imm;
                6: pc = imm;
                7: if (c) pc = imm;
                8: if (z) pc = imm;
                14: exp_out_q.push_back('{t + 4, 0, a});
                15: begin halted = 1; exp_halt = t + 4; end
                0: ;
                default: begin
`ifdef SAP_CPU_ILLEGAL_TRAP_EN
                    halted = 1;
                    exp_halt = t + 4;
                    exp_out_q.push_back('{t + 4, 0, 255});
`endif
                end
            endcase
            t += 4;
        end
    endtask

    initial begin
        logic [127:0] img;
        int n12, last12;
        rst8 = 1'b0;
        rst12 = 1'b0;

        vecs[0]  = '{"ldi_out",  128'h57E0F000_00000000_00000000_00000000, 12, 1, 8'h07, 0, 4'h0, 8'h00};
        vecs[1]  = '{"add_c",    128'h5F2EE0F0_00000000_00000000_0000F500, 18, 1, 8'h04, 0, 4'h0, 8'h00};
        vecs[2]  = '{"add_jc",   128'h5F2E76F0_0000E0F0_00000000_0000F500, 22, 1, 8'h04, 0, 4'h0, 8'h00};
        vecs[3]  = '{"add_jz_nt",128'h5F2E86E0_F000F000_00000000_0000F500, 22, 1, 8'h04, 0, 4'h0, 8'h00};
        vecs[4]  = '{"sub_jz",   128'h533D86F0_0000E0F0_00000000_00030000, 22, 1, 8'h00, 0, 4'h0, 8'h00};
        vecs[5]  = '{"sub_jc",   128'h533D76F0_0000E0F0_00000000_00030000, 22, 1, 8'h00, 0, 4'h0, 8'h00};
        vecs[6]  = '{"sta",      128'h594CF000_00000000_00000000_00000000, 12, 0, 8'h00, 1, 4'hC, 8'h09};
        vecs[7]  = '{"selfmod",  128'h1F42F0F0_00000000_00000000_000000E0, 18, 1, 8'hE0, 1, 4'h2, 8'hE0};
        vecs[8]  = '{"jmp",      128'h63F0F057_E0F00000_00000000_00000000, 16, 1, 8'h07, 0, 4'h0, 8'h00};
`ifdef SAP_CPU_ILLEGAL_TRAP_EN
        vecs[9]  = '{"illegal",  128'h9057E0F0_00000000_00000000_00000000,  4, 1, 8'hFF, 0, 4'h0, 8'h00};
`else
        vecs[9]  = '{"illegal",  128'h9057E0F0_00000000_00000000_00000000, 16, 1, 8'h07, 0, 4'h0, 8'h00};
`endif
        vecs[10] = '{"sub_borrow",128'h513D76E0_F000F000_00000000_00030000, 22, 1, 8'hFE, 0, 4'h0, 8'h00};
        vecs[11] = '{"add_zero", 128'h512E86F0_0000E0F0_00000000_0000FF00, 22, 1, 8'h00, 0, 4'h0, 8'h00};

        foreach (vecs[k]) begin
            reset8(vecs[k].img);
            run8(40);
            chk({vecs[k].name, "_halt"}, dut_halt, vecs[k].halt_e);
            chk({vecs[k].name, "_nout"}, dut_out_q.size(), vecs[k].nout);
            if (vecs[k].nout > 0 && dut_out_q.size() > 0)
                chk({vecs[k].name, "_out"}, dut_out_q[$].v, vecs[k].out);
            chk({vecs[k].name, "_nwr"}, dut_wr_q.size(), vecs[k].nwr);
            if (vecs[k].nwr > 0 && dut_wr_q.size() > 0)
                chk({vecs[k].name, "_wr"}, {dut_wr_q[0].a[3:0], dut_wr_q[0].v[7:0]},
                    {vecs[k].waddr, vecs[k].wdata});
            chk({vecs[k].name, "_quiet_after_halt"}, after_halt, 0);
            chk({vecs[k].name, "_re_we_overlap"}, overlap, 0);
        end

        // PC wraps 15 -> 0 over a memory of NOPs and fetching resumes at address 0.
        reset8(128'h0);
        for (int e = 1; e <= 65; e++) begin
            @(posedge clk);
            #1;
            if (e == 60) chk("pc_before_wrap", pc8, 4'hF);
            if (e == 64) chk("pc_wrapped", pc8, 4'h0);
            if (e == 65) chk("fetch_after_wrap", {re8, addr8}, {1'b1, 4'h0});
        end

        // Reset during MEM_W of LDA aborts at once; restart runs from address 0 with A cleared.
        reset8(128'h1E000000_00000000_00000000_00007700);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_lda_read", {re8, addr8}, {1'b1, 4'hE});
        #2;
        rst8 = 1'b0;
        #1;
        chk("abort_outputs", {4'h0, pc8, addr8, re8, we8, wdata8, out8, ov8, halted8}, 32'd0);
        load8(128'hE0F00000_00000000_00000000_00000000);
        @(negedge clk);
        rst8 = 1'b1;
        run8(12);
        chk("abort_restart_nout", dut_out_q.size(), 1);
        if (dut_out_q.size() > 0) chk("abort_restart_a", dut_out_q[0].v, 0);
        chk("abort_restart_halt", dut_halt, 8);

        // Random programs against the instruction-level model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
                img[127-8*i -: 8] = {op, 4'($urandom_range(0, 15))};
            end
            model8(img, 300);
            reset8(img);
            run8(300);
            chk("rnd_halt", dut_halt, exp_halt);
            chk("rnd_nout", dut_out_q.size(), exp_out_q.size());
            for (int i = 0; i < dut_out_q.size() && i < exp_out_q.size(); i++)
                chk("rnd_out", {dut_out_q[i].e[15:0], dut_out_q[i].v[15:0]},
                    {exp_out_q[i].e[15:0], exp_out_q[i].v[15:0]});
            chk("rnd_nwr", dut_wr_q.size(), exp_wr_q.size());
            for (int i = 0; i < dut_wr_q.size() && i < exp_wr_q.size(); i++)
                chk("rnd_wr", {dut_wr_q[i].e[15:0], dut_wr_q[i].a[7:0], dut_wr_q[i].v[7:0]},
                    {exp_wr_q[i].e[15:0], exp_wr_q[i].a[7:0], exp_wr_q[i].v[7:0]});
            chk("rnd_overlap", overlap, 0);
            chk("rnd_quiet_after_halt", after_halt, 0);
        end

        // 12-bit build: LDI zero-extends its 8-bit immediate.
        for (int i = 0; i < 256; i++) ram12[i] = 12'h000;
        ram12[0] = 12'h5AB;
        ram12[1] = 12'hE00;
        ram12[2] = 12'hF00;
        @(negedge clk);
        rst12 = 1'b1;
        n12 = 0;
        last12 = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (ov12) begin
                n12++;
                last12 = int'(out12);
            end
        end
        chk("w12_nout", n12, 1);
        chk("w12_ldi", last12, 32'h0AB);
        chk("w12_halt_pc", {halted12, pc12}, {1'b1, 8'h03});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
